// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment codes,
// the hex-to-segment table and the scan FSM state encoding.
package seg7_pkg;

    // Segment patterns are active-low {a,b,c,d,e,f,g}, bit6 = a, bit0 = g.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Nibble value -> segment pattern, index 0 first.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b1110010,  // c
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Scan FSM encoding: a digit is either lit (SHOW) or in its dead gap (DEAD).
    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Largest of three values; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder for one common-anode digit.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the active-low segment pattern.
    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for NUM_DIGITS common-anode 7-segment digits
// on a shared segment bus. New data is held in pending registers and only
// copied to the displayed (shadow) registers at the start of a frame, so a
// frame never mixes old and new values. Pins are registered one cycle after
// the FSM state that selects them.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 16,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dash_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_tick
);

    localparam int CW = $clog2(max3(CLK_DIV, DEAD_CYCLES, 2));
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    // One complete set of display contents.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dash;
    } disp_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IW-1:0]   idx, idx_nx, idx_inc;
    logic            enter_show;
    logic            commit;

    disp_t           incoming, pending, shadow;

    logic [3:0]      nib;
    logic            dig_blank;
    logic            dig_dash;
    logic [6:0]      hex_seg;

    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;
    logic                  tick_d;

    // Bundle the load-side inputs into one display record.
    always_comb begin
        incoming.data  = data_in;
        incoming.blank = blank_mask;
        incoming.dash  = dash_mask;
    end

    // Next digit index; the last digit, and any unreachable code above it, wraps to 0.
    always_comb begin
        idx_inc = (idx >= LAST_IDX) ? '0 : idx + IW'(1);
    end

    // FSM state register: phase, phase counter and digit index.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_DEAD;
            cnt   <= '0;
            idx   <= LAST_IDX;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state logic: SHOW for CLK_DIV cycles, then DEAD for DEAD_CYCLES (skipped when 0).
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CW'(1);
        idx_nx     = idx;
        enter_show = 1'b0;
        unique case (state)
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_nx = '0;
                    if (DEAD_CYCLES == 0) begin
                        enter_show = 1'b1;
                        idx_nx     = idx_inc;
                    end else begin
                        state_nx = ST_DEAD;
                    end
                end
            end
            ST_DEAD: begin
                if (DEAD_CYCLES == 0 || cnt == DEAD_LAST) begin
                    cnt_nx     = '0;
                    state_nx   = ST_SHOW;
                    idx_nx     = idx_inc;
                    enter_show = 1'b1;
                end
            end
        endcase
        commit = enter_show && (idx_inc == '0);
    end

    // Pending capture on load; shadow takes pending (or a same-cycle load) at frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            shadow.data  <= '0;
            shadow.blank <= '1;
            shadow.dash  <= '0;
        end else begin
            if (load) begin
                pending <= incoming;
            end
            if (commit) begin
                shadow <= load ? incoming : pending;
            end
        end
    end

    // Select the active digit's nibble and mask bits; an out-of-range index reads as blank.
    always_comb begin
        nib       = '0;
        dig_blank = 1'b1;
        dig_dash  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = shadow.data[4*i +: 4];
                dig_blank = shadow.blank[i];
                dig_dash  = shadow.dash[i];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nib),
        .seg    (hex_seg)
    );

    // Output decode: one anode low while SHOW of a non-blank digit; blank beats dash beats hex.
    always_comb begin
        an_d   = '1;
        seg_d  = SEG_BLANK;
        tick_d = (state == ST_SHOW) && (idx == '0) && (cnt == '0);
        if (state == ST_SHOW && !dig_blank) begin
            an_d  = ~(NUM_DIGITS'(1) << idx);
            seg_d = dig_dash ? SEG_DASH : hex_seg;
        end
    end

    // Output registers; frame_tick lines up with the first lit cycle of digit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= '1;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            frame_tick <= tick_d;
        end
    end

endmodule
